// File: rtl/morse_emit_char.sv
// morse_emit_char: Morse character transmitter.
//
// Accepts one character (element pattern + length + word_end) over a valid/ready handshake and
// keys the `signal` line with dit/dah marks, dit-length inter-element spaces and a trailing
// character gap (dah_time+1 ticks) or word gap (word_time+1 ticks). All timing is counted in
// ce-asserted clock cycles.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   ce                 clock enable; every tick and state change requires ce=1
//   dit_time/dah_time/word_time   element, character-gap and word-gap times (0 treated as 1)
//   valid / ready      character handshake; ready = idle & ce
//   len, dits_dahs     element count and pattern (bit i = element i, 1 = dah)
//   word_end           follow the character with a word gap instead of a character gap
//   signal             keyed line, 1 = mark
//   ceo                one-cycle pulse (on a ce=1 cycle) once the trailing gap completes
//   abort              only with MORSE_EMIT_ABORT_EN: drop the character in flight
//
// Optional feature macro: MORSE_EMIT_ABORT_EN (adds the abort input).
module morse_emit_char #(
   parameter int unsigned PULSE_CNT_W   = 12,
   parameter int unsigned MORSE_LEN_W   = 4,
   parameter int unsigned MAX_MORSE_LEN = 8,
   parameter int          DEBUG         = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ce,
`ifdef MORSE_EMIT_ABORT_EN
   input  logic                     abort,
`endif
   input  logic [PULSE_CNT_W-1:0]   dit_time,
   input  logic [PULSE_CNT_W-1:0]   dah_time,
   input  logic [PULSE_CNT_W-1:0]   word_time,
   input  logic                     valid,
   output logic                     ready,
   input  logic [MORSE_LEN_W-1:0]   len,
   input  logic [MAX_MORSE_LEN-1:0] dits_dahs,
   input  logic                     word_end,
   output logic                     signal,
   output logic                     ceo
);

   localparam logic [PULSE_CNT_W-1:0] CntOne = PULSE_CNT_W'(1);
   localparam logic [MORSE_LEN_W-1:0] LenMax = MORSE_LEN_W'(MAX_MORSE_LEN);
   localparam logic [MORSE_LEN_W-1:0] LenOne = MORSE_LEN_W'(1);

   typedef enum logic [1:0] {StIdle, StMark, StSpace, StGap} state_e;

   state_e                   state_q, state_d;
   logic [PULSE_CNT_W-1:0]   cnt_q, cnt_d;
   logic [MAX_MORSE_LEN-1:0] pat_q, pat_d;
   logic [MORSE_LEN_W-1:0]   rem_q, rem_d;
   logic [PULSE_CNT_W-1:0]   dit_q, dit_d;
   logic [PULSE_CNT_W-1:0]   dah_q, dah_d;
   logic [PULSE_CNT_W-1:0]   word_q, word_d;
   logic                     word_end_q, word_end_d;
   logic                     signal_q, signal_d;
   logic                     ceo_q, ceo_d;

   logic [PULSE_CNT_W-1:0]   dit_n, dah_n, word_n;
   logic [MORSE_LEN_W-1:0]   len_c;

   function automatic logic [PULSE_CNT_W-1:0] nz(input logic [PULSE_CNT_W-1:0] t);
      return (t == '0) ? CntOne : t;
   endfunction

   assign ready  = (state_q == StIdle) & ce;
   assign signal = signal_q;
   // ceo_q is held across ce=0 cycles so the pulse lands on the next ce=1 cycle.
   assign ceo    = ceo_q & ce;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pat_d      = pat_q;
      rem_d      = rem_q;
      dit_d      = dit_q;
      dah_d      = dah_q;
      word_d     = word_q;
      word_end_d = word_end_q;
      signal_d   = signal_q;
      ceo_d      = ceo_q;

      dit_n  = nz(dit_time);
      dah_n  = nz(dah_time);
      word_n = nz(word_time);
      len_c  = (len > LenMax) ? LenMax : len;

      if (ce) begin
         ceo_d = 1'b0;
         // Marks/spaces load time-1 and expire at 0; gaps load time and expire at 0,
         // giving time+1 ticks without needing a wider counter.
         unique case (state_q)
            StIdle: begin
               if (valid) begin
                  dit_d      = dit_n;
                  dah_d      = dah_n;
                  word_d     = word_n;
                  word_end_d = word_end;
                  if (len_c == '0) begin
                     state_d  = StGap;
                     signal_d = 1'b0;
                     cnt_d    = word_end ? word_n : dah_n;
                     pat_d    = dits_dahs;
                     rem_d    = '0;
                  end else begin
                     state_d  = StMark;
                     signal_d = 1'b1;
                     cnt_d    = (dits_dahs[0] ? dah_n : dit_n) - CntOne;
                     pat_d    = dits_dahs >> 1;
                     rem_d    = len_c - LenOne;
                  end
               end
            end
            StMark: begin
               if (cnt_q == '0) begin
                  signal_d = 1'b0;
                  if (rem_q != '0) begin
                     state_d = StSpace;
                     cnt_d   = dit_q - CntOne;
                  end else begin
                     state_d = StGap;
                     cnt_d   = word_end_q ? word_q : dah_q;
                  end
               end else begin
                  cnt_d = cnt_q - CntOne;
               end
            end
            StSpace: begin
               if (cnt_q == '0) begin
                  state_d  = StMark;
                  signal_d = 1'b1;
                  cnt_d    = (pat_q[0] ? dah_q : dit_q) - CntOne;
                  pat_d    = pat_q >> 1;
                  rem_d    = rem_q - LenOne;
               end else begin
                  cnt_d = cnt_q - CntOne;
               end
            end
            StGap: begin
               if (cnt_q == '0) begin
                  state_d = StIdle;
                  ceo_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q - CntOne;
               end
            end
            default: state_d = StIdle;
         endcase

`ifdef MORSE_EMIT_ABORT_EN
         if (abort && (state_q != StIdle)) begin
            state_d  = StIdle;
            signal_d = 1'b0;
            ceo_d    = 1'b0;
            cnt_d    = '0;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         pat_q      <= '0;
         rem_q      <= '0;
         dit_q      <= '0;
         dah_q      <= '0;
         word_q     <= '0;
         word_end_q <= 1'b0;
         signal_q   <= 1'b0;
         ceo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pat_q      <= pat_d;
         rem_q      <= rem_d;
         dit_q      <= dit_d;
         dah_q      <= dah_d;
         word_q     <= word_d;
         word_end_q <= word_end_d;
         signal_q   <= signal_d;
         ceo_q      <= ceo_d;
      end
   end

   if (DEBUG != 0) begin : g_debug
`ifndef SYNTHESIS
      always @(posedge clk) begin
         if (valid && ready) begin
            $display("morse_emit_char: accept pattern=%b len=%0d word_end=%0b",
                     dits_dahs, len, word_end);
         end
      end
`endif
   end

endmodule

// File: tb/tb_morse_emit_char.sv
module tb_morse_emit_char;

   localparam int PW = 12;
   localparam int LW = 4;
   localparam int ML = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ce = 1'b1;
   logic [PW-1:0] dit_time = 10;
   logic [PW-1:0] dah_time = 30;
   logic [PW-1:0] word_time = 70;
   logic          valid = 1'b0;
   logic          ready;
   logic [LW-1:0] len = '0;
   logic [ML-1:0] dits_dahs = '0;
   logic          word_end = 1'b0;
   logic          signal;
   logic          ceo;
`ifdef MORSE_EMIT_ABORT_EN
   logic          abort = 1'b0;
`endif

   morse_emit_char #(
      .PULSE_CNT_W   (PW),
      .MORSE_LEN_W   (LW),
      .MAX_MORSE_LEN (ML),
      .DEBUG         (0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ce        (ce),
`ifdef MORSE_EMIT_ABORT_EN
      .abort     (abort),
`endif
      .dit_time  (dit_time),
      .dah_time  (dah_time),
      .word_time (word_time),
      .valid     (valid),
      .ready     (ready),
      .len       (len),
      .dits_dahs (dits_dahs),
      .word_end  (word_end),
      .signal    (signal),
      .ceo       (ceo)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input int got, input int want);
      n_chk++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
   endtask

   // Clock-enable generator: 0 = always on, 1 = one cycle in three, 2 = random.
   int ce_mode = 0;
   int ce_ph   = 0;
   always @(posedge clk) begin
      #1;
      case (ce_mode)
         1: begin
            ce = (ce_ph == 2);
            ce_ph = (ce_ph + 1) % 3;
         end
         2: ce = ($urandom_range(0, 1) == 1);
         default: ce = 1'b1;
      endcase
   end

   // Reference model: a character becomes a list of line levels, one per ce tick.
   typedef bit wave_t[$];

   function automatic wave_t mk_wave(input logic [ML-1:0] pat, input int l, input bit we,
                                     input int dt, input int ah, input int wd);
      wave_t w;
      int    n;
      if (dt == 0) dt = 1;
      if (ah == 0) ah = 1;
      if (wd == 0) wd = 1;
      n = (l > ML) ? ML : l;
      for (int i = 0; i < n; i++) begin
         int t;
         t = pat[i] ? ah : dt;
         repeat (t) w.push_back(1'b1);
         if (i != n - 1) repeat (dt) w.push_back(1'b0);
      end
      repeat ((we ? wd : ah) + 1) w.push_back(1'b0);
      return w;
   endfunction

   wave_t wave;
   bit    ceo_pend = 1'b0;

   // Per-cycle compare, then advance the model to the next rising edge.
   always @(negedge clk) begin
      bit ab;
      if (!rst_n) begin
         wave.delete();
         ceo_pend = 1'b0;
      end
      chk("signal", signal, (wave.size() != 0) ? int'(wave[0]) : 0);
      chk("ready", ready, ((wave.size() == 0) && ce) ? 1 : 0);
      chk("ceo", ceo, (ceo_pend && ce) ? 1 : 0);
      ab = 1'b0;
`ifdef MORSE_EMIT_ABORT_EN
      ab = abort;
`endif
      if (rst_n && ce) begin
         if (wave.size() != 0) begin
            if (ab) wave.delete();
            else begin
               void'(wave.pop_front());
               if (wave.size() == 0) ceo_pend = 1'b1;
            end
         end else begin
            ceo_pend = 1'b0;
            if (valid) wave = mk_wave(dits_dahs, int'(len), word_end, int'(dit_time),
                                      int'(dah_time), int'(word_time));
         end
      end
   end

   int got_runs[$];
   int exp_runs[$];

   task automatic send(input logic [ML-1:0] p, input int l, input bit we);
      bit ok;
      @(posedge clk);
      #2;
      dits_dahs = p;
      len       = l[LW-1:0];
      word_end  = we;
      valid     = 1'b1;
      ok        = 1'b0;
      for (int i = 0; i < 4000 && !ok; i++) begin
         @(negedge clk);
         if (ready) ok = 1'b1;
      end
      @(posedge clk);
      #2;
      valid = 1'b0;
      chk("accept", ok, 1);
   endtask

   // Run-length record of `signal` (in clk cycles) from acceptance until ceo.
   task automatic measure(input string name);
      bit done;
      bit cur;
      int cur_len;
      int n;
      got_runs.delete();
      done    = 1'b0;
      cur     = 1'b0;
      cur_len = 0;
      for (int i = 0; i < 20000 && !done; i++) begin
         @(negedge clk);
         if (ceo) done = 1'b1;
         else begin
            if (cur_len != 0 && signal != cur) begin
               got_runs.push_back(cur_len);
               cur_len = 0;
            end
            cur = signal;
            cur_len++;
         end
      end
      if (cur_len != 0) got_runs.push_back(cur_len);
      chk({name, "_ceo_seen"}, done, 1);
      chk({name, "_nruns"}, got_runs.size(), exp_runs.size());
      n = (got_runs.size() < exp_runs.size()) ? got_runs.size() : exp_runs.size();
      for (int i = 0; i < n; i++) chk($sformatf("%s_run%0d", name, i), got_runs[i], exp_runs[i]);
   endtask

   task automatic wait_idle();
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 20000 && !idle; i++) begin
         @(negedge clk);
         if (wave.size() == 0 && !ceo_pend) idle = 1'b1;
      end
      chk("drain", idle, 1);
   endtask

   initial begin
      wave_t w;
      int    ones;

      // Pin the model against hand-counted totals for "--.-." at 10/30/70.
      w = mk_wave(8'b0000_1011, 5, 1'b0, 10, 30, 70);
      ones = 0;
      foreach (w[i]) ones += int'(w[i]);
      chk("model_len", w.size(), 181);
      chk("model_ones", ones, 110);

      repeat (3) @(posedge clk);
      chk("reset_signal", signal, 0);
      chk("reset_ceo", ceo, 0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_ready", ready, 1);

      exp_runs = '{10, 31};
      send(8'b0000_0000, 1, 1'b0);
      measure("dot");

      exp_runs = '{30, 10, 30, 10, 10, 10, 30, 10, 10, 31};
      send(8'b0000_1011, 5, 1'b0);
      measure("dashdashdot");

      exp_runs = '{30, 10, 30, 10, 30, 71};
      send(8'b0000_0111, 3, 1'b1);
      measure("dashes_word");

      exp_runs = '{71};
      send(8'b0000_0000, 0, 1'b1);
      measure("len0_word");

      exp_runs.delete();
      for (int i = 0; i < 15; i++) exp_runs.push_back(10);
      exp_runs.push_back(31);
      send(8'b0000_0000, ML + 2, 1'b0);
      measure("clamp");

      // One tick in three: each tick is 3 clks; ceo then waits for the next ce cycle.
      ce_mode = 1;
      exp_runs = '{30, 30, 30, 30, 30, 95};
      send(8'b0000_0000, 3, 1'b0);
      measure("ce_third");
      ce_mode = 0;
      repeat (2) @(posedge clk);

      dit_time = 0;
      dah_time = 0;
      word_time = 0;
      exp_runs = '{1, 2};
      send(8'b0000_0000, 1, 1'b0);
      measure("zero_times");

      dah_time = '1;
      exp_runs = '{4096};
      send(8'b0000_0000, 0, 1'b0);
      measure("allones_gap");

      dit_time = 10;
      dah_time = 30;
      word_time = 70;
      send(8'b0000_0001, 1, 1'b0);
      repeat (15) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_dah_signal", signal, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_release_ready", ready, 1);

`ifdef MORSE_EMIT_ABORT_EN
      send(8'b0000_0000, 2, 1'b0);
      repeat (13) @(posedge clk);
      #2 abort = 1'b1;
      @(posedge clk);
      #2 abort = 1'b0;
      @(negedge clk);
      chk("abort_signal", signal, 0);
      chk("abort_ready", ready, 1);
`endif

      for (int k = 0; k < 40; k++) begin
         ce_mode   = $urandom_range(0, 2);
         dit_time  = PW'($urandom_range(0, 6));
         dah_time  = PW'($urandom_range(0, 12));
         word_time = PW'($urandom_range(0, 20));
         send(ML'($urandom), $urandom_range(0, 15), $urandom_range(0, 1) == 1);
         // Scramble inputs while the character is in flight.
         dit_time  = PW'($urandom_range(0, 6));
         dah_time  = PW'($urandom_range(0, 12));
         dits_dahs = ML'($urandom);
         len       = LW'($urandom);
`ifdef MORSE_EMIT_ABORT_EN
         if ($urandom_range(0, 4) == 0) begin
            repeat ($urandom_range(1, 30)) @(posedge clk);
            #2 abort = 1'b1;
            @(posedge clk);
            #2 abort = 1'b0;
         end
`endif
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      wait_idle();
      ce_mode = 0;
      repeat (4) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
